// File: rtl/memory_board_ctrl.sv
// ----------------------------------------------------------------------------
// memory_board_ctrl
//   Game-state controller for a 4x4 memory-card board. Moves a cursor over the
//   16 slots, flips cards face-up on select, compares each picked pair and
//   hides a mismatched pair again after HIDE_DELAY cycles.
//
// Parameters
//   HIDE_DELAY   cycles a mismatched pair stays visible (>= 2)
//
// Ports
//   i_clk        system clock
//   i_reset      synchronous active-high reset
//   i_new_game   one-cycle pulse, restarts the game and latches i_layout
//   i_layout     pair ID per slot, slot i = bits [3i+2:3i]
//   i_btn_*      debounced one-cycle button pulses (sel > up > down > left > right)
//   o_cursor     selected slot, row = [3:2], column = [1:0]
//   o_face_up    per-slot face-up (renderer enable)
//   o_matched    per-slot solved flag
//   o_game_over  high while every slot is matched
//   o_moves      compared-pair count, saturating at 255
//
// Build option
//   MEMCTRL_MOVES_EN  when defined the moves counter is built; otherwise
//                     o_moves is tied to zero.
// ----------------------------------------------------------------------------
module memory_board_ctrl #(
   parameter int HIDE_DELAY = 25_000_000
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_new_game,
   input  logic [47:0] i_layout,
   input  logic        i_btn_up,
   input  logic        i_btn_down,
   input  logic        i_btn_left,
   input  logic        i_btn_right,
   input  logic        i_btn_sel,
   output logic [3:0]  o_cursor,
   output logic [15:0] o_face_up,
   output logic [15:0] o_matched,
   output logic        o_game_over,
   output logic [7:0]  o_moves
);

   localparam int CW = $clog2(HIDE_DELAY);

   typedef enum logic [2:0] {
      S_WAIT_FIRST,
      S_WAIT_SECOND,
      S_COMPARE,
      S_SHOW_MISS,
      S_DONE
   } state_t;

   state_t        r_state, w_state;
   logic [3:0]    r_cursor, w_cursor;
   logic [15:0]   r_face_up, w_face_up;
   logic [15:0]   r_matched, w_matched;
   logic          r_game_over, w_game_over;
   logic [3:0]    r_first, w_first;
   logic [3:0]    r_second, w_second;
   logic [CW-1:0] r_cnt, w_cnt;
   logic [2:0]    r_ids [16];

   logic          w_sel_ok;
   logic [15:0]   w_pair_mask;

`ifdef MEMCTRL_MOVES_EN
   logic [7:0]    r_moves;
   logic          w_moves_inc;
`endif

   // A select only counts on a face-down slot; this also rejects re-picking
   // the first card and any already-matched slot.
   assign w_sel_ok    = i_btn_sel && !r_face_up[r_cursor];
   assign w_pair_mask = (16'd1 << r_first) | (16'd1 << r_second);

   always_comb begin
      w_state     = r_state;
      w_cursor    = r_cursor;
      w_face_up   = r_face_up;
      w_matched   = r_matched;
      w_game_over = r_game_over;
      w_first     = r_first;
      w_second    = r_second;
      w_cnt       = r_cnt;
`ifdef MEMCTRL_MOVES_EN
      w_moves_inc = 1'b0;
`endif

      // btn_sel owns the cycle even when it is dropped, so a simultaneous
      // direction pulse is never acted on.
      if (r_state != S_DONE && !i_btn_sel) begin
         if (i_btn_up)
            w_cursor = {r_cursor[3:2] - 2'd1, r_cursor[1:0]};
         else if (i_btn_down)
            w_cursor = {r_cursor[3:2] + 2'd1, r_cursor[1:0]};
         else if (i_btn_left)
            w_cursor = {r_cursor[3:2], r_cursor[1:0] - 2'd1};
         else if (i_btn_right)
            w_cursor = {r_cursor[3:2], r_cursor[1:0] + 2'd1};
      end

      case (r_state)
         S_WAIT_FIRST: begin
            if (w_sel_ok) begin
               w_face_up[r_cursor] = 1'b1;
               w_first             = r_cursor;
               w_state             = S_WAIT_SECOND;
            end
         end
         S_WAIT_SECOND: begin
            if (w_sel_ok) begin
               w_face_up[r_cursor] = 1'b1;
               w_second            = r_cursor;
               w_state             = S_COMPARE;
            end
         end
         S_COMPARE: begin
`ifdef MEMCTRL_MOVES_EN
            w_moves_inc = 1'b1;
`endif
            if (r_ids[r_first] == r_ids[r_second]) begin
               w_matched   = r_matched | w_pair_mask;
               // game_over rises on the same edge as the final matched update
               w_game_over = (w_matched == 16'hFFFF);
               w_state     = w_game_over ? S_DONE : S_WAIT_FIRST;
            end else begin
               w_cnt   = CW'(HIDE_DELAY - 1);
               w_state = S_SHOW_MISS;
            end
         end
         S_SHOW_MISS: begin
            if (r_cnt == '0) begin
               w_face_up = r_face_up & ~w_pair_mask;
               w_state   = S_WAIT_FIRST;
            end else begin
               w_cnt = r_cnt - 1'b1;
            end
         end
         S_DONE: ;
         default: w_state = S_WAIT_FIRST;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset || i_new_game) begin
         r_state     <= S_WAIT_FIRST;
         r_cursor    <= 4'd0;
         r_face_up   <= 16'h0000;
         r_matched   <= 16'h0000;
         r_game_over <= 1'b0;
         r_first     <= 4'd0;
         r_second    <= 4'd0;
         r_cnt       <= '0;
         for (int i = 0; i < 16; i++)
            r_ids[i] <= i_layout[3*i +: 3];
      end else begin
         r_state     <= w_state;
         r_cursor    <= w_cursor;
         r_face_up   <= w_face_up;
         r_matched   <= w_matched;
         r_game_over <= w_game_over;
         r_first     <= w_first;
         r_second    <= w_second;
         r_cnt       <= w_cnt;
      end
   end

`ifdef MEMCTRL_MOVES_EN
   always_ff @(posedge i_clk) begin
      if (i_reset || i_new_game)
         r_moves <= 8'd0;
      else if (w_moves_inc && r_moves != 8'hFF)
         r_moves <= r_moves + 8'd1;
   end
   assign o_moves = r_moves;
`else
   assign o_moves = 8'd0;
`endif

   assign o_cursor    = r_cursor;
   assign o_face_up   = r_face_up;
   assign o_matched   = r_matched;
   assign o_game_over = r_game_over;

endmodule

// File: doc/memory_board_ctrl.md
# memory_board_ctrl

Game-state controller for the 4x4 memory-card board. It takes debounced button pulses, moves a cursor over the 16 card slots and flips cards face-up. It compares each selected pair and hides mismatched pairs after a programmable delay. It sits directly upstream of the 16 per-slot card renderers: it drives each renderer's enable, and the cursor slot index drives the highlight renderer's 4-bit position.

## Interface
- HIDE_DELAY, 25_000_000: clock cycles a mismatched pair stays visible (≥2; 0.5 s at 50 MHz).
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- new_game  in  1  one-cycle pulse; restarts the game from any state.
- layout  in  48  pair ID per slot; slot i uses bits [3i+2:3i]; each 3-bit ID appears exactly twice; sampled only at reset or new_game.
- btn_up, btn_down, btn_left, btn_right, btn_sel  in  1 each  one-cycle pulses, already debounced.
- cursor  out  4  selected slot; row = cursor[3:2], column = cursor[1:0]; slot encoding matches the renderer position code.
- face_up  out  16  bit i set = slot i shown face-up (renderer enable).
- matched  out  16  bit i set = slot i permanently solved.
- game_over  out  1  high while all 16 slots are matched.
- moves  out  8  count of compared pairs, saturating at 255.

## Operation
- States:
  - WAIT_FIRST: waits for the first pick of a pair.
  - WAIT_SECOND: waits for the second pick.
  - COMPARE: one cycle.
  - SHOW_MISS: holds the mismatched pair visible.
  - DONE: board complete.
- Button priority: at most one button action per cycle; btn_sel > up > down > left > right.
- Cursor moves:
  - Allowed in every state except DONE.
  - up/down change the row and left/right change the column, each mod 4 (wrap within the same column/row: left from column 0 goes to column 3 of that row; up from row 0 goes to row 3).
- btn_sel in WAIT_FIRST on a slot with face_up=0:
  - Set face_up[cursor].
  - Record first = cursor.
  - Go to WAIT_SECOND.
- btn_sel in WAIT_SECOND on a slot with face_up=0:
  - Set face_up[cursor].
  - Record second = cursor.
  - Go to COMPARE.
- btn_sel is ignored when:
  - the slot is already face-up (this covers re-selecting first and selecting any matched slot);
  - the state is COMPARE, SHOW_MISS or DONE.
- COMPARE:
  - moves increments by 1 (saturating).
  - If layout IDs are equal: set matched[first] and matched[second]. If matched then becomes 16'hFFFF, go to DONE; otherwise go to WAIT_FIRST.
  - If IDs differ: load the delay counter with HIDE_DELAY-1 and go to SHOW_MISS.
- SHOW_MISS:
  - Decrement the counter each cycle.
  - At 0: clear face_up[first] and face_up[second], then go to WAIT_FIRST.
- Invariant: matched bits always imply the corresponding face_up bits; matched bits are never cleared except by reset or new_game.
- reset or new_game (any state, including mid-SHOW_MISS):
  - state WAIT_FIRST, cursor 0, face_up 0, matched 0, moves 0, game_over 0, counter 0.
  - Latch layout.
  - reset has priority over new_game; new_game has priority over buttons in the same cycle.
- layout with an ID appearing other than twice is a caller error. Behaviour stays defined: compares use the latched layout verbatim, and DONE may be unreachable.

## Timing
- All outputs are registered, with no combinational input-to-output path.
- Output values after reset: cursor 4'd0, face_up 16'h0000, matched 16'h0000, game_over 0, moves 8'd0.
- Cursor button at edge n: cursor holds the new value after edge n.
- First/second btn_sel at edge n: face_up bit set after edge n.
- Match (second pick at edge n):
  - matched bits and moves update after edge n+1 (the COMPARE edge).
  - game_over asserts on the same edge as the final matched update.
- Mismatch (second pick at edge n): moves updates after n+1; both face_up bits clear after edge n+1+HIDE_DELAY.
- Buttons during SHOW_MISS and COMPARE: cursor moves are accepted, btn_sel is dropped with no queueing.

## Configuration
- MEMCTRL_MOVES_EN defined: the moves counter is implemented as above.
- MEMCTRL_MOVES_EN undefined:
  - No counter register is built.
  - moves is tied to 8'd0.
  - All other behaviour is identical.

## Test plan
All scenarios use HIDE_DELAY=4 and a layout where slot i has ID i>>1, so slots 0 and 1 are a pair.
- Cursor wrap: from reset, btn_left then btn_up -> cursor 4'd3 after the first pulse, then 4'd15; btn_down -> 4'd3.
- Match: sel on slot 0, btn_right, sel on slot 1 -> face_up=16'h0003, matched=16'h0003 one cycle after the second sel; moves=1.
- Mismatch: sel on slot 0, sel on slot 2 -> face_up=16'h0005 for exactly 5 cycles after the second sel, then 16'h0000; moves=1; a btn_sel pulse during the window changes nothing.
- Ignored sel: sel on slot 0 twice -> state stays WAIT_SECOND, face_up=16'h0001, moves=0.
- Full game: match all 8 pairs -> matched=16'hFFFF and game_over=1 on the same edge; moves=8; further buttons, including cursor moves, are ignored.
- new_game mid-SHOW_MISS, with a new layout on the same cycle -> all outputs return to their reset values the next cycle; the new layout is used for the subsequent compare; with MEMCTRL_MOVES_EN undefined, moves stays 0 throughout.
